// File: rtl/placement_pkg.sv
// Shared types and constants for the object placement arbiter.
package placement_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CHECK,
    GRANT
  } state_t;

  localparam int unsigned TILE_SIZE = 64;
  localparam int unsigned X_OFF     = 15;
  localparam int unsigned Y_OFF     = 48;

  typedef struct packed {
    logic       valid;
    logic [4:0] col;
    logic [4:0] row;
  } tile_t;

  // Player start area: tiles no object may ever occupy, stored as {col, row}
  localparam int unsigned NUM_RSV = 3;
  localparam logic [9:0] RSV_TILES [NUM_RSV] = '{
    {5'd0, 5'd0},
    {5'd1, 5'd0},
    {5'd0, 5'd1}
  };

  function automatic logic is_reserved(input logic [4:0] col, input logic [4:0] row);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_RSV; i++)
      if ({col, row} == RSV_TILES[i]) hit = 1'b1;
    return hit;
  endfunction

  // Pixel coordinate of a tile edge; 11 bits hold every legal tile
  function automatic logic [10:0] tile_px(input logic [4:0] idx, input logic [10:0] off);
    return 11'(idx) * 11'(TILE_SIZE) + off;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: first set request at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic           found;
  logic [IDX_W:0] slot;

  // Scan requests starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    slot    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (32'(slot) >= NUM_REQ) slot = slot - (IDX_W+1)'(NUM_REQ);
      if (!found && req[slot[IDX_W-1:0]]) begin
        winner = slot[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/placement_arbiter.sv
// Round-robin placement arbiter sharing one random tile source between placers.
// Optional macro PLACE_STATS_EN enables the saturating reject_count counter.
module placement_arbiter
  import placement_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned COL_MAX   = 9,
  parameter int unsigned ROW_MAX   = 6,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [4:0]         random_num1,
  input  logic [4:0]         random_num2,
  input  logic               clear,
  output logic [NUM_REQ-1:0] grant,
  output logic               place_fail,
  output logic [10:0]        topLeftX,
  output logic [10:0]        topLeftY,
  output logic               busy,
  output logic [7:0]         reject_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t           state, state_nx;
  logic [IDX_W-1:0] rr_ptr, winner_q, arb_winner;
  logic             any_req;
  logic [3:0]       retry_cnt;
  logic [4:0]       col_q, row_q;
  logic             fail_q;
  logic             tile_ok;
  tile_t            occ [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (arb_winner),
    .any_req (any_req)
  );

  // Candidate tile must be on-field, outside the player start and not held by another placer
  always_comb begin
    tile_ok = (col_q <= 5'(COL_MAX)) && (row_q <= 5'(ROW_MAX)) && !is_reserved(col_q, row_q);
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (occ[i].valid && occ[i].col == col_q && occ[i].row == row_q && IDX_W'(i) != winner_q)
        tile_ok = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; clear aborts from any state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = SAMPLE;
      SAMPLE:  state_nx = CHECK;
      CHECK:   state_nx = (tile_ok || retry_cnt == 4'(MAX_RETRY)) ? GRANT : SAMPLE;
      GRANT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // Grant pulse; clear suppresses a grant falling in the same cycle
  always_comb begin
    grant      = '0;
    place_fail = 1'b0;
    if (state == GRANT && !clear) begin
      grant[winner_q] = 1'b1;
      place_fail      = fail_q;
    end
  end

  assign busy = (state != IDLE);

  // Winner, candidate tile, retry count, coordinates, occupancy and rotate pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      winner_q  <= '0;
      retry_cnt <= '0;
      col_q     <= '0;
      row_q     <= '0;
      fail_q    <= 1'b0;
      rr_ptr    <= '0;
      topLeftX  <= '0;
      topLeftY  <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) occ[i] <= '0;
    end else if (clear) begin
      rr_ptr <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) occ[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          winner_q  <= arb_winner;
          retry_cnt <= '0;
          fail_q    <= 1'b0;
        end
        SAMPLE: begin
          col_q <= random_num1;
          row_q <= random_num2;
        end
        CHECK: begin
          if (tile_ok) begin
            topLeftX       <= tile_px(col_q, 11'(X_OFF));
            topLeftY       <= tile_px(row_q, 11'(Y_OFF));
            occ[winner_q]  <= '{valid: 1'b1, col: col_q, row: row_q};
          end else if (retry_cnt == 4'(MAX_RETRY)) begin
            fail_q <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt + 4'd1;
          end
        end
        GRANT: rr_ptr <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        default: ;
      endcase
    end
  end

`ifdef PLACE_STATS_EN
  // Saturating count of rejected candidate tiles since reset or level clear
  always_ff @(posedge clk) begin
    if (reset || clear)
      reject_count <= '0;
    else if (state == CHECK && !tile_ok && reject_count != 8'hFF)
      reject_count <= reject_count + 8'd1;
  end
`else
  assign reject_count = '0;
`endif

endmodule

// File: doc/placement_arbiter.md
Name: placement_arbiter

Overview:
- Shares the single random-number source (random_num1/random_num2) between NUM_REQ object placers (door, idol, enemy spawners).
- Round-robin grants one requester at a time and samples a tile. It rejects the tile if it is off-field, reserved, or already held by another requester, and retries on rejection.
- Returns pixel top-left coordinates with a one-cycle grant pulse. Sits between the LFSR block and the per-object position registers; cleared per level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- COL_MAX, 9, highest legal tile column
- ROW_MAX, 6, highest legal tile row
- MAX_RETRY, 15, rejections allowed before failing a request (4-bit)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level request per placer; held until its grant
- random_num1  in  5  random column candidate
- random_num2  in  5  random row candidate
- clear  in  1  new level: forget all placed tiles, abort in-flight request
- grant  out  NUM_REQ  one-hot, one-cycle pulse to the served requester
- place_fail  out  1  one-cycle pulse with grant when retries are exhausted
- topLeftX  out  11  col*64+15 of the granted tile
- topLeftY  out  11  row*64+48 of the granted tile
- busy  out  1  high in any state other than IDLE
- reject_count  out  8  saturating rejection counter (optional feature)

Behaviour:
- Reset: state IDLE; grant=0, place_fail=0, topLeftX=0, topLeftY=0, busy=0, rr_ptr=0, all occupancy valid bits=0, retry_cnt=0, reject_count=0.
- IDLE:
  - If req!=0, the rr_arbiter picks the first set bit at or after rr_ptr (wrapping). Register the winner index, retry_cnt=0, go to SAMPLE.
- SAMPLE:
  - Latch col=random_num1, row=random_num2, go to CHECK.
- CHECK: a tile is rejected if any of:
  - col>COL_MAX or row>ROW_MAX;
  - (col,row) is (0,0), (1,0) or (0,1), the player start;
  - (col,row) equals a valid occupancy entry of a different requester.
- CHECK, tile accepted:
  - Compute topLeftX/Y in 11 bits (col<<6 + 15, row<<6 + 48; no overflow for legal tiles).
  - Write the winner's occupancy entry, overwriting any previous entry of its own.
  - Go to GRANT.
- CHECK, tile rejected:
  - If retry_cnt==MAX_RETRY, set fail and go to GRANT; topLeftX/Y and occupancy are unchanged.
  - Otherwise retry_cnt++ and go back to SAMPLE.
- GRANT:
  - grant[winner]=1 for exactly this cycle; place_fail=fail.
  - rr_ptr=winner+1 (mod NUM_REQ); go to IDLE.
- Latency:
  - req seen in IDLE in cycle t gives grant in cycle t+3 with zero rejections; each rejection adds 2 cycles.
  - Worst case: t+3+2*MAX_RETRY.
- Request rules:
  - A req still high in the cycle after its grant is treated as a new request; it re-places and replaces its own tile.
  - A req dropped before its grant: the arbiter still completes and pulses the grant, and the requester ignores it.
- clear:
  - Any state → IDLE next cycle; all valid bits=0, no grant that cycle, rr_ptr=0.
  - topLeftX/Y hold their values.
  - clear beats a grant scheduled for the same cycle.
- Requests arriving while busy wait; req is level-sensitive, so none are lost.

Optional Feature:
- PLACE_STATS_EN defined:
  - reject_count increments on every CHECK rejection and saturates at 255.
  - It is cleared by reset or clear.
- Not defined: reject_count is tied to 0 and no counter logic is synthesized.

Decomposition:
- placement_pkg:
  - state enum (IDLE, SAMPLE, CHECK, GRANT);
  - TILE_SIZE=64, X_OFF=15, Y_OFF=48;
  - tile_t struct {valid, col[4:0], row[4:0]};
  - the player-start reserved tile list.
- Sub-module rr_arbiter: combinational rotate-priority pick from req and rr_ptr, giving winner index and any_req. Instantiated once.

Test Plan:
- Single request: req=0001, random (3,2) → grant=0001 three cycles after req; topLeftX=207, topLeftY=176; place_fail=0.
- Off-field then legal: random (12,2) then (4,5) → one rejection; grant at t+5; topLeftX=271, topLeftY=368.
- Collision: req0 placed at (3,2); req1 sees (3,2) then (6,1) → req1 granted at (6,1), topLeftX=399, topLeftY=112; a later req0 re-request landing on (3,2) is accepted (own tile).
- Round robin: req=1111 held continuously → grants in order 0001,0010,0100,1000,0001; no requester is starved.
- Retry exhaustion: random fixed at (0,0) → 16 rejections, then grant with place_fail=1; topLeftX/Y unchanged; reject_count=16 with PLACE_STATS_EN.
- clear in CHECK state → no grant, busy=0 next cycle; a subsequent request for a previously occupied tile (3,2) is accepted.
